// File: rtl/sig_display.sv
// Signature display for the signature analyser: captures each final signature,
// multiplexes it onto four HP-charset 7-segment digits, stretches the gate pulse
// into a visible LED and flags signatures that changed between captures.
module sig_display #(
    parameter int SCAN_DIV     = 1024,
    parameter int GATE_STRETCH = 50000
) (
    input  logic        clock,
    input  logic        reset_l,
    input  logic        sig_valid,
    input  logic [15:0] signature,
    input  logic        hold,
    output logic [3:0]  digit_sel,
    output logic [6:0]  segments,
    output logic        gate_led,
    output logic        unstable
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int GW = $clog2(GATE_STRETCH + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [GW-1:0] GATE_LOAD = GW'(GATE_STRETCH);

    logic [15:0]   r_disp_sig;
    logic          r_have_sig;
    logic          r_unstable;
    logic [GW-1:0] r_gate_cnt;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_digit_idx;
    logic [3:0]    r_digit_sel;
    logic [6:0]    r_segments;

    logic          w_capture;
    logic          w_wrap;
    logic [3:0]    w_nibble;
    logic [6:0]    w_glyph;
    logic [3:0]    w_sel_onehot;

    assign w_capture = sig_valid && !hold;
    assign w_wrap    = (r_presc == PRESC_MAX);

    // Capture path: hold freezes the displayed value and the stability flag.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            r_disp_sig <= 16'h0000;
            r_have_sig <= 1'b0;
            r_unstable <= 1'b0;
        end else if (w_capture) begin
            r_disp_sig <= signature;
            r_have_sig <= 1'b1;
            r_unstable <= r_have_sig && (signature != r_disp_sig);
        end
    end

    // Every pulse reloads the stretch counter, even while held.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            r_gate_cnt <= '0;
        end else if (sig_valid) begin
            r_gate_cnt <= GATE_LOAD;
        end else if (r_gate_cnt != '0) begin
            r_gate_cnt <= r_gate_cnt - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            r_presc     <= '0;
            r_digit_idx <= 2'd3;
        end else begin
            r_presc <= w_wrap ? '0 : r_presc + 1'b1;
            if (w_wrap) begin
                r_digit_idx <= r_digit_idx - 2'd1;
            end
        end
    end

    always_comb begin
        w_nibble = r_disp_sig[3:0];
        case (r_digit_idx)
            2'd3:    w_nibble = r_disp_sig[15:12];
            2'd2:    w_nibble = r_disp_sig[11:8];
            2'd1:    w_nibble = r_disp_sig[7:4];
            default: w_nibble = r_disp_sig[3:0];
        endcase
    end

    // HP signature charset: 0-9, A, C, F, H, P, U.
    always_comb begin
        w_glyph = 7'h00;
        case (w_nibble)
            4'h0: w_glyph = 7'h3F;
            4'h1: w_glyph = 7'h06;
            4'h2: w_glyph = 7'h5B;
            4'h3: w_glyph = 7'h4F;
            4'h4: w_glyph = 7'h66;
            4'h5: w_glyph = 7'h6D;
            4'h6: w_glyph = 7'h7D;
            4'h7: w_glyph = 7'h07;
            4'h8: w_glyph = 7'h7F;
            4'h9: w_glyph = 7'h6F;
            4'hA: w_glyph = 7'h77;
            4'hB: w_glyph = 7'h39;
            4'hC: w_glyph = 7'h71;
            4'hD: w_glyph = 7'h76;
            4'hE: w_glyph = 7'h73;
            default: w_glyph = 7'h3E;
        endcase
    end

    assign w_sel_onehot = 4'b0001 << r_digit_idx;

    // Digit enable and segment pattern are registered together so they never skew.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            r_digit_sel <= 4'b0000;
            r_segments  <= 7'h00;
        end else begin
            r_digit_sel <= w_sel_onehot;
            r_segments  <= r_have_sig ? w_glyph : 7'h40;
        end
    end

    assign digit_sel = r_digit_sel;
    assign segments  = r_segments;
    assign gate_led  = (r_gate_cnt != '0);
    assign unstable  = r_unstable;

endmodule
